// File: rtl/cp0_exc_ctrl.sv
// Coprocessor-0 exception/interrupt controller: holds SR, Cause, EPC and PRId and
// decides each cycle whether the PC vectors to the handler or returns to EPC.
module cp0_exc_ctrl #(
    parameter logic [31:0] PRID_VAL = 32'h0000_4C34
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [5:0]  HWInt,
    input  logic [31:0] PcM,
    input  logic        BdM,
    input  logic        ValidM,
    input  logic        ExcM,
    input  logic [4:0]  ExcCodeM,
    input  logic        EretM,
    input  logic        We,
    input  logic [4:0]  Addr,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IntReq,
    output logic        EretReq,
    output logic [31:0] EpcOut
);

    localparam logic [4:0]  REG_SR    = 5'd12;
    localparam logic [4:0]  REG_CAUSE = 5'd13;
    localparam logic [4:0]  REG_EPC   = 5'd14;
    localparam logic [4:0]  REG_PRID  = 5'd15;
    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

    logic [5:0]  sr_im;
    logic        sr_exl;
    logic        sr_ie;
    logic        cause_bd;
    logic [5:0]  cause_ip;
    logic [4:0]  cause_exc;
    logic [31:0] epc;

    logic        ip;
    logic        take;
    logic        wr_sr;
    logic        wr_epc;
    logic [31:0] epc_hw;

    // Accept/return decisions are combinational so the PC can act at the same edge.
    always_comb begin
        ip      = (|(cause_ip & sr_im)) & sr_ie & ~sr_exl;
        take    = ValidM & (ip | ExcM);
        IntReq  = take;
        EretReq = ValidM & EretM & ~take;
        wr_sr   = We && (Addr == REG_SR);
        wr_epc  = We && (Addr == REG_EPC);
        epc_hw  = (BdM ? (PcM - 32'd4) : PcM) & WORD_MASK;
        EpcOut  = wr_epc ? (Din & WORD_MASK) : epc;
    end

    always_comb begin
        Dout = 32'd0;
        case (Addr)
            REG_SR:    Dout = {16'd0, sr_im, 8'd0, sr_exl, sr_ie};
            REG_CAUSE: Dout = {cause_bd, 15'd0, cause_ip, 3'd0, cause_exc, 2'd0};
            REG_EPC:   Dout = epc;
            REG_PRID:  Dout = PRID_VAL;
            default:   Dout = 32'd0;
        endcase
    end

    // Hardware updates on take/eret are applied after mtc0 so they win on conflict.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sr_im     <= 6'd0;
            sr_exl    <= 1'b0;
            sr_ie     <= 1'b0;
            cause_bd  <= 1'b0;
            cause_ip  <= 6'd0;
            cause_exc <= 5'd0;
            epc       <= 32'd0;
        end else begin
            cause_ip <= HWInt;
            if (wr_sr) begin
                sr_im  <= Din[15:10];
                sr_exl <= Din[1];
                sr_ie  <= Din[0];
            end
            if (wr_epc) begin
                epc <= Din & WORD_MASK;
            end
            if (take) begin
                sr_exl    <= 1'b1;
                cause_exc <= ip ? 5'd0 : ExcCodeM;
                if (!sr_exl) begin
                    epc      <= epc_hw;
                    cause_bd <= BdM;
                end
            end else if (EretReq) begin
                sr_exl <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Directed bench for cp0_exc_ctrl: interrupt/exception entry, eret, mtc0
// forwarding, held interrupts and asynchronous reset.
module tb_cp0_exc_ctrl;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [5:0]  HWInt;
    logic [31:0] PcM;
    logic        BdM;
    logic        ValidM;
    logic        ExcM;
    logic [4:0]  ExcCodeM;
    logic        EretM;
    logic        We;
    logic [4:0]  Addr;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic        IntReq;
    logic        EretReq;
    logic [31:0] EpcOut;

    int checks = 0;
    int errors = 0;
    logic [31:0] rv;

    cp0_exc_ctrl #(.PRID_VAL(32'h0000_4C34)) dut (
        .Clk(Clk), .Reset(Reset), .HWInt(HWInt), .PcM(PcM), .BdM(BdM),
        .ValidM(ValidM), .ExcM(ExcM), .ExcCodeM(ExcCodeM), .EretM(EretM),
        .We(We), .Addr(Addr), .Din(Din), .Dout(Dout), .IntReq(IntReq),
        .EretReq(EretReq), .EpcOut(EpcOut)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d);
        Addr = a;
        #1;
        d = Dout;
    endtask

    task automatic test_reset();
        Reset = 1'b1; HWInt = 6'd0; PcM = 32'd0; BdM = 1'b0; ValidM = 1'b0;
        ExcM = 1'b0; ExcCodeM = 5'd0; EretM = 1'b0; We = 1'b0; Addr = 5'd0; Din = 32'd0;
        #3;
        checks++; if (IntReq !== 1'b0) begin errors++; $display("FAIL reset_intreq got %b exp 0", IntReq); end
        checks++; if (EretReq !== 1'b0) begin errors++; $display("FAIL reset_eretreq got %b exp 0", EretReq); end
        checks++; if (EpcOut !== 32'd0) begin errors++; $display("FAIL reset_epcout got %h exp 0", EpcOut); end
        rd(5'd15, rv);
        checks++; if (rv !== 32'h0000_4C34) begin errors++; $display("FAIL reset_prid got %h exp 00004c34", rv); end
        rd(5'd3, rv);
        checks++; if (rv !== 32'd0) begin errors++; $display("FAIL reset_other_reg got %h exp 0", rv); end
        tick();
        Reset = 1'b0;
        // writes to Cause and PRId must be ignored
        We = 1'b1; Addr = 5'd13; Din = 32'hFFFF_FFFF;
        tick();
        Addr = 5'd15;
        tick();
        We = 1'b0;
        rd(5'd13, rv);
        checks++; if (rv !== 32'd0) begin errors++; $display("FAIL cause_write_ignored got %h exp 0", rv); end
        rd(5'd15, rv);
        checks++; if (rv !== 32'h0000_4C34) begin errors++; $display("FAIL prid_write_ignored got %h exp 00004c34", rv); end
    endtask

    task automatic test_interrupt();
        We = 1'b1; Addr = 5'd12; Din = 32'h0000_0401;
        tick();
        We = 1'b0;
        HWInt = 6'b000001; ValidM = 1'b1; PcM = 32'h3010; BdM = 1'b0;
        #1;
        checks++; if (IntReq !== 1'b0) begin errors++; $display("FAIL int_before_sample got %b exp 0", IntReq); end
        tick();
        checks++; if (IntReq !== 1'b1) begin errors++; $display("FAIL int_after_sample got %b exp 1", IntReq); end
        tick();
        checks++; if (IntReq !== 1'b0) begin errors++; $display("FAIL int_masked_in_handler got %b exp 0", IntReq); end
        rd(5'd14, rv);
        checks++; if (rv !== 32'h3010) begin errors++; $display("FAIL int_epc got %h exp 00003010", rv); end
        rd(5'd13, rv);
        checks++; if (rv !== 32'h0000_0400) begin errors++; $display("FAIL int_cause got %h exp 00000400", rv); end
        rd(5'd12, rv);
        checks++; if (rv !== 32'h0000_0403) begin errors++; $display("FAIL int_sr got %h exp 00000403", rv); end
    endtask

    task automatic test_handler_eret();
        EretM = 1'b1;
        #1;
        checks++; if (EretReq !== 1'b1) begin errors++; $display("FAIL eret_req got %b exp 1", EretReq); end
        checks++; if (EpcOut !== 32'h3010) begin errors++; $display("FAIL eret_epcout got %h exp 00003010", EpcOut); end
        tick();
        EretM = 1'b0; PcM = 32'h3050;
        rd(5'd12, rv);
        checks++; if (rv !== 32'h0000_0401) begin errors++; $display("FAIL eret_sr got %h exp 00000401", rv); end
        checks++; if (IntReq !== 1'b1) begin errors++; $display("FAIL int_after_eret got %b exp 1", IntReq); end
        tick();
        rd(5'd14, rv);
        checks++; if (rv !== 32'h3050) begin errors++; $display("FAIL reentry_epc got %h exp 00003050", rv); end
    endtask

    task automatic test_exc_delay_slot();
        // leave the handler with the interrupt line dropped
        HWInt = 6'd0; EretM = 1'b1;
        tick();
        EretM = 1'b0;
        ExcM = 1'b1; ExcCodeM = 5'd12; PcM = 32'h3024; BdM = 1'b1;
        #1;
        checks++; if (IntReq !== 1'b1) begin errors++; $display("FAIL exc_intreq got %b exp 1", IntReq); end
        tick();
        ExcCodeM = 5'd4; PcM = 32'h4000; BdM = 1'b0;
        rd(5'd14, rv);
        checks++; if (rv !== 32'h3020) begin errors++; $display("FAIL exc_bd_epc got %h exp 00003020", rv); end
        rd(5'd13, rv);
        checks++; if (rv !== 32'h8000_0030) begin errors++; $display("FAIL exc_bd_cause got %h exp 80000030", rv); end
        checks++; if (IntReq !== 1'b1) begin errors++; $display("FAIL nested_exc_intreq got %b exp 1", IntReq); end
        tick();
        ExcM = 1'b0;
        rd(5'd14, rv);
        checks++; if (rv !== 32'h3020) begin errors++; $display("FAIL nested_epc_kept got %h exp 00003020", rv); end
        rd(5'd13, rv);
        checks++; if (rv !== 32'h8000_0010) begin errors++; $display("FAIL nested_cause got %h exp 80000010", rv); end
        EretM = 1'b1;
        tick();
        EretM = 1'b0;
    endtask

    task automatic test_valid_hold();
        ValidM = 1'b0; HWInt = 6'b000001;
        tick();
        for (int i = 0; i < 3; i++) begin
            checks++; if (IntReq !== 1'b0) begin errors++; $display("FAIL hold_bubble%0d got %b exp 0", i, IntReq); end
            tick();
        end
        ValidM = 1'b1; PcM = 32'h3100;
        #1;
        checks++; if (IntReq !== 1'b1) begin errors++; $display("FAIL hold_taken got %b exp 1", IntReq); end
        tick();
        rd(5'd14, rv);
        checks++; if (rv !== 32'h3100) begin errors++; $display("FAIL hold_epc got %h exp 00003100", rv); end
    endtask

    task automatic test_mtc0_epc_fwd();
        HWInt = 6'd0; We = 1'b1; Addr = 5'd14; Din = 32'h3047; EretM = 1'b1;
        #1;
        checks++; if (EretReq !== 1'b1) begin errors++; $display("FAIL fwd_eretreq got %b exp 1", EretReq); end
        checks++; if (EpcOut !== 32'h3044) begin errors++; $display("FAIL fwd_epcout got %h exp 00003044", EpcOut); end
        checks++; if (Dout !== 32'h3100) begin errors++; $display("FAIL fwd_no_bypass got %h exp 00003100", Dout); end
        tick();
        We = 1'b0; EretM = 1'b0;
        rd(5'd14, rv);
        checks++; if (rv !== 32'h3044) begin errors++; $display("FAIL fwd_epc_written got %h exp 00003044", rv); end
        rd(5'd12, rv);
        checks++; if (rv !== 32'h0000_0401) begin errors++; $display("FAIL fwd_sr got %h exp 00000401", rv); end
    endtask

    task automatic test_priority();
        ValidM = 1'b0; HWInt = 6'b000001;
        tick();
        // exception, interrupt and an mtc0 clearing EXL all in one cycle
        ValidM = 1'b1; ExcM = 1'b1; ExcCodeM = 5'd12; PcM = 32'h3200; BdM = 1'b0;
        We = 1'b1; Addr = 5'd12; Din = 32'h0000_0401;
        #1;
        checks++; if (IntReq !== 1'b1) begin errors++; $display("FAIL prio_intreq got %b exp 1", IntReq); end
        tick();
        We = 1'b0; ExcM = 1'b0;
        rd(5'd13, rv);
        checks++; if (rv !== 32'h0000_0400) begin errors++; $display("FAIL prio_cause got %h exp 00000400", rv); end
        rd(5'd14, rv);
        checks++; if (rv !== 32'h3200) begin errors++; $display("FAIL prio_epc got %h exp 00003200", rv); end
        rd(5'd12, rv);
        checks++; if (rv !== 32'h0000_0403) begin errors++; $display("FAIL prio_hw_over_mtc0 got %h exp 00000403", rv); end
    endtask

    task automatic test_reset_mid_handler();
        #2;
        Reset = 1'b1;
        rd(5'd12, rv);
        checks++; if (rv !== 32'd0) begin errors++; $display("FAIL rst_sr got %h exp 0", rv); end
        rd(5'd13, rv);
        checks++; if (rv !== 32'd0) begin errors++; $display("FAIL rst_cause got %h exp 0", rv); end
        rd(5'd14, rv);
        checks++; if (rv !== 32'd0) begin errors++; $display("FAIL rst_epc got %h exp 0", rv); end
        checks++; if (IntReq !== 1'b0) begin errors++; $display("FAIL rst_intreq got %b exp 0", IntReq); end
        tick();
        Reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_interrupt();
        test_handler_eret();
        test_exc_delay_slot();
        test_valid_hold();
        test_mtc0_epc_fwd();
        test_priority();
        test_reset_mid_handler();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cp0_exc_ctrl.md
# cp0_exc_ctrl

Coprocessor-0 exception/interrupt controller that sequences the program counter. It holds SR, Cause, EPC and PRId, and decides each cycle whether the PC vectors to the handler at 0x00004180 (`IntReq`) or returns to EPC (`EretReq`). It sits beside the M stage: it consumes M-stage status and drives the PC's `IntReq` input, the NPC mux return path and the pipeline flush.

## Interface
- `PRID_VAL`, 32'h0000_4C34, constant returned for PRId (reg 15)
- `Clk`  in  1  clock, rising edge
- `Reset`  in  1  asynchronous, active-high; clears all state
- `HWInt`  in  6  external interrupt lines, level-sensitive
- `PcM`  in  32  PC of M-stage instruction
- `BdM`  in  1  M-stage instruction is in a branch delay slot
- `ValidM`  in  1  M stage holds a real instruction (not a bubble)
- `ExcM`  in  1  synchronous exception raised by the M-stage instruction
- `ExcCodeM`  in  5  code for `ExcM`
- `EretM`  in  1  M-stage instruction is eret
- `We`  in  1  mtc0 write enable
- `Addr`  in  5  CP0 register number, read and write
- `Din`  in  32  mtc0 write data
- `Dout`  out  32  mfc0 read data, combinational
- `IntReq`  out  1  vector to handler; to PC and flush logic
- `EretReq`  out  1  return from handler; NPC selects `EpcOut`
- `EpcOut`  out  32  return address

## Operation
- Registers: SR(12) = IM[15:10], EXL[1], IE[0], other bits read 0. Cause(13) = BD[31], IP[15:10], ExcCode[6:2], other bits 0. EPC(14) = 32 bits, [1:0] always 0. PRId(15) = `PRID_VAL`. Any other `Addr` reads 0.
- Reset values: SR=0, Cause=0, EPC=0. Outputs after reset: `IntReq`=0, `EretReq`=0, `EpcOut`=0.
- IP register: `Cause.IP <= HWInt` every cycle. This gives one cycle of sampling latency.
- Interrupt pending: `ip = |(Cause.IP & SR.IM) & SR.IE & ~SR.EXL`.
- Accept: `take = ValidM & (ip | ExcM)`. `IntReq = take`, combinational.
- On `take`, at the next edge:
  - EXL<=1.
  - ExcCode <= 0 if `ip`, else `ExcCodeM`. Interrupt has priority over an exception in the same cycle.
  - If EXL was 0: EPC <= (`BdM` ? `PcM`-4 : `PcM`) with [1:0] cleared, and BD <= `BdM`.
  - If EXL was already 1 (nested synchronous exception): EPC and BD are unchanged.
- A pending interrupt while `ValidM`=0 is held, not lost. It is taken on the first cycle with `ValidM`=1, provided it is still enabled.
- Eret: `EretReq = ValidM & EretM & ~take`. On `EretReq`, EXL<=0 at the next edge. A simultaneous `take` suppresses eret.
- mtc0: on `We` with `Addr` in {12, 14}, the register is written at the edge.
  - Writes to Cause and PRId are ignored.
  - A hardware update on `take` or `EretReq` overrides an mtc0 to the same field in the same cycle.
- `EpcOut` = (`We` & `Addr`==14) ? {`Din`[31:2],2'b0} : EPC. This forwards a same-cycle mtc0 EPC to an eret.
- Modes: USER (EXL=0) and HANDLER (EXL=1).
  - USER to HANDLER on `take`.
  - HANDLER to USER on `EretReq`.
  - In HANDLER, interrupts are masked and only `ExcM` can assert `IntReq`.

## Timing
- `IntReq` and `EretReq` are combinational within the cycle. The PC loads 0x00004180 or `EpcOut` at the same edge at which CP0 state updates.
- HWInt-to-`IntReq` latency: 1 cycle after `HWInt` rises, with IE=1, EXL=0, IM bit set and `ValidM`=1.
- Reset mid-handler clears EXL immediately, with no clock edge. `IntReq` drops in the same cycle.
- `Dout` reflects register state before the current edge. There is no read-after-write bypass except `EpcOut`.

## Test plan
- Reset, then mtc0 SR=0x0000_0401, then `HWInt`=6'b000001 with `ValidM`=1 and `PcM`=0x3010, `BdM`=0 → `IntReq`=1 the cycle after IP samples. Then EPC=0x3010, EXL=1, ExcCode=0, and `Dout`(13)=0x0000_0400.
- `ExcM`=1, `ExcCodeM`=12, `PcM`=0x3024, `BdM`=1 → `IntReq`=1. Then EPC=0x3020, Cause=0x8000_0030.
- Interrupt pending while `ValidM`=0 for 3 cycles → `IntReq`=0 throughout. `IntReq`=1 on the first `ValidM`=1 cycle.
- In HANDLER: raise `HWInt` → no `IntReq`. Then `EretM`=1 → `EretReq`=1, `EpcOut`=EPC, EXL=0 next cycle. The interrupt is taken on the next valid cycle.
- `We`=1, `Addr`=14, `Din`=0x3047 together with `EretM`=1 → `EpcOut`=0x3044. EPC=0x3044 afterwards.
- `ip` and `ExcM` together → ExcCode=0. Assert `Reset` mid-handler → SR, Cause and EPC read 0 immediately, and `IntReq`=0.
